control_sequencer: RTL and testbench

//  Hardwired control unit for the 16-register bus datapath. Fetches an instruction
//  (PC->MAR, memory->MDR->IR), decodes IR and steps the datapath through register/ALU

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control for the 16-register bus datapath; Moore outputs, one bus source per cycle.
// Define ILLEGAL_TRAP_EN to halt on illegal opcodes (default: illegal opcodes execute as NOP).
module control_sequencer #(
   parameter int MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        mdr_out,
   output logic        zlo_out,
   output logic        zhi_out,
   output logic        mar_enable,
   output logic        mdr_enable,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        z_enable,
   output logic        hi_enable,
   output logic        lo_enable,
   output logic        pc_increment,
   output logic        read,
   output logic [15:0] reg_out_sel,
   output logic [15:0] reg_in_sel,
   output logic [4:0]  op_code,
   output logic [3:0]  t_state,
   output logic        halted,
   output logic        illegal
);

   localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH0 = 4'd1,
      S_FETCH1 = 4'd2,
      S_FETCH2 = 4'd3,
      S_T3     = 4'd4,
      S_T4     = 4'd5,
      S_T5     = 4'd6,
      S_T6     = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   state_t          state, state_nxt, end_nxt;
   logic [CW-1:0]   cnt;
   logic [4:0]      opcode;
   logic [3:0]      ra, rb, rc;
   logic            is_alu, is_md, is_nop, is_halt, is_ill;
   logic            unused_ir_bits;

   assign opcode  = ir[31:27];
   assign ra      = ir[26:23];
   assign rb      = ir[22:19];
   assign rc      = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];

   assign is_alu  = (opcode <= 5'h0C);
   assign is_md   = (opcode == 5'h0F) || (opcode == 5'h10);
   assign is_nop  = (opcode == 5'h1E);
   assign is_halt = (opcode == 5'h1F);
   assign is_ill  = !(is_alu || is_md || is_nop || is_halt);

   // Instruction end is not a state of its own: it folds into the last execute cycle.
   assign end_nxt = run ? S_FETCH0 : S_IDLE;
   assign t_state = state;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH0)
            cnt <= CW'(MEM_WAIT);
         else if (state == S_FETCH1 && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   logic illegal_c;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         illegal_q <= 1'b0;
      else if (state == S_T3 && is_ill)
         illegal_q <= 1'b1;
   end

   assign illegal = illegal_c;
`else
   assign illegal = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      pc_out       = 1'b0;
      mdr_out      = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      mar_enable   = 1'b0;
      mdr_enable   = 1'b0;
      ir_enable    = 1'b0;
      y_enable     = 1'b0;
      z_enable     = 1'b0;
      hi_enable    = 1'b0;
      lo_enable    = 1'b0;
      pc_increment = 1'b0;
      read         = 1'b0;
      reg_out_sel  = 16'h0000;
      reg_in_sel   = 16'h0000;
      op_code      = 5'h00;
      halted       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_c    = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (run)
               state_nxt = S_FETCH0;
         end
         S_FETCH0: begin
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
            state_nxt    = S_FETCH1;
         end
         S_FETCH1: begin
            read       = 1'b1;
            mdr_enable = 1'b1;
            if (cnt == '0)
               state_nxt = S_FETCH2;
         end
         S_FETCH2: begin
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            if (is_alu || is_md) begin
               reg_out_sel = 16'h0001 << rb;
               y_enable    = 1'b1;
               state_nxt   = S_T4;
            end else if (is_halt) begin
               halted    = 1'b1;
               state_nxt = S_HALT;
            end else if (is_ill) begin
`ifdef ILLEGAL_TRAP_EN
               halted    = 1'b1;
               illegal_c = 1'b1;
               state_nxt = S_HALT;
`else
               state_nxt = end_nxt;
`endif
            end else begin
               state_nxt = end_nxt;
            end
         end
         S_T4: begin
            reg_out_sel = 16'h0001 << rc;
            op_code     = opcode;
            z_enable    = 1'b1;
            state_nxt   = S_T5;
         end
         S_T5: begin
            zlo_out = 1'b1;
            if (is_md) begin
               lo_enable = 1'b1;
               state_nxt = S_T6;
            end else begin
               reg_in_sel = 16'h0001 << ra;
               state_nxt  = end_nxt;
            end
         end
         S_T6: begin
            zhi_out   = 1'b1;
            hi_enable = 1'b1;
            state_nxt = end_nxt;
         end
         S_HALT: begin
            halted = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            illegal_c = illegal_q;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle control words compared against a fetch/decode/execute model.
module tb_control_sequencer;

   localparam int MW = 1;
`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   localparam logic [51:0] B_PC_OUT  = 52'd1 << 51;
   localparam logic [51:0] B_MDR_OUT = 52'd1 << 50;
   localparam logic [51:0] B_ZLO     = 52'd1 << 49;
   localparam logic [51:0] B_ZHI     = 52'd1 << 48;
   localparam logic [51:0] B_MAR_EN  = 52'd1 << 47;
   localparam logic [51:0] B_MDR_EN  = 52'd1 << 46;
   localparam logic [51:0] B_IR_EN   = 52'd1 << 45;
   localparam logic [51:0] B_Y_EN    = 52'd1 << 44;
   localparam logic [51:0] B_Z_EN    = 52'd1 << 43;
   localparam logic [51:0] B_HI_EN   = 52'd1 << 42;
   localparam logic [51:0] B_LO_EN   = 52'd1 << 41;
   localparam logic [51:0] B_PC_INC  = 52'd1 << 40;
   localparam logic [51:0] B_READ    = 52'd1 << 39;
   localparam logic [51:0] B_HALTED  = 52'd1 << 38;
   localparam logic [51:0] B_ILLEGAL = 52'd1 << 37;
   localparam logic [51:0] V_FETCH0  = B_PC_OUT | B_MAR_EN | B_PC_INC;

   logic        clk = 1'b0;
   logic        clr, run;
   logic [31:0] ir;
   logic        pc_out, mdr_out, zlo_out, zhi_out;
   logic        mar_enable, mdr_enable, ir_enable, y_enable, z_enable;
   logic        hi_enable, lo_enable, pc_increment, read, halted, illegal;
   logic [15:0] reg_out_sel, reg_in_sel;
   logic [4:0]  op_code;
   logic [3:0]  t_state;
   logic [51:0] obs;

   always #5 clk = ~clk;

   control_sequencer #(.MEM_WAIT(MW)) dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir),
      .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
      .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
      .y_enable(y_enable), .z_enable(z_enable), .hi_enable(hi_enable),
      .lo_enable(lo_enable), .pc_increment(pc_increment), .read(read),
      .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel), .op_code(op_code),
      .t_state(t_state), .halted(halted), .illegal(illegal)
   );

   assign obs = {pc_out, mdr_out, zlo_out, zhi_out, mar_enable, mdr_enable, ir_enable,
                 y_enable, z_enable, hi_enable, lo_enable, pc_increment, read, halted,
                 illegal, op_code, reg_out_sel, reg_in_sel};

   int          checks = 0;
   int          failures = 0;
   logic [51:0] exp_q[$];
   bit          exp_halt, exp_ill;
   bit          in_fetch0 = 1'b0;

   function automatic logic [51:0] osel(input logic [3:0] r);
      return 52'd1 << (16 + r);
   endfunction

   function automatic logic [51:0] isel(input logic [3:0] r);
      return 52'd1 << r;
   endfunction

   function automatic bit is_illegal_op(input logic [4:0] op);
      return !(op <= 5'h0C || op == 5'h0F || op == 5'h10 || op == 5'h1E || op == 5'h1F);
   endfunction

   task automatic check(input string tag, input logic [51:0] e);
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic check_state(input string tag, input logic [3:0] e);
      checks++;
      assert (t_state === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, t_state, e);
      end
   endtask

   // Expected control words, one per cycle, for a whole instruction.
   task automatic build(input logic [31:0] v);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = v[31:27]; ra = v[26:23]; rb = v[22:19]; rc = v[18:15];
      exp_q.delete();
      exp_halt = 1'b0;
      exp_ill  = 1'b0;
      exp_q.push_back(V_FETCH0);
      for (int i = 0; i <= MW; i++) exp_q.push_back(B_READ | B_MDR_EN);
      exp_q.push_back(B_MDR_OUT | B_IR_EN);
      if (op <= 5'h0C || op == 5'h0F || op == 5'h10) begin
         exp_q.push_back(osel(rb) | B_Y_EN);
         exp_q.push_back(osel(rc) | B_Z_EN | {15'd0, op, 32'd0});
         if (op <= 5'h0C) begin
            exp_q.push_back(B_ZLO | isel(ra));
         end else begin
            exp_q.push_back(B_ZLO | B_LO_EN);
            exp_q.push_back(B_ZHI | B_HI_EN);
         end
      end else if (op == 5'h1F) begin
         exp_q.push_back(B_HALTED);
         exp_halt = 1'b1;
      end else if (is_illegal_op(op) && TRAP) begin
         exp_q.push_back(B_HALTED | B_ILLEGAL);
         exp_halt = 1'b1;
         exp_ill  = 1'b1;
      end else begin
         exp_q.push_back(52'd0);
      end
   endtask

   // run is released after the cycle with index drop_at (-1: keep run high).
   task automatic exec(input string tag, input logic [31:0] v, input int drop_at);
      build(v);
      ir  = v;
      run = 1'b1;
      for (int i = (in_fetch0 ? 1 : 0); i < exp_q.size(); i++) begin
         @(posedge clk); #1;
         check($sformatf("%s_c%0d", tag, i), exp_q[i]);
         if (i == drop_at) run = 1'b0;
      end
      if (exp_halt) begin
         for (int k = 0; k < 3; k++) begin
            run = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("%s_halt%0d", tag, k), B_HALTED | (exp_ill ? B_ILLEGAL : 52'd0));
         end
         in_fetch0 = 1'b0;
      end else begin
         @(posedge clk); #1;
         check($sformatf("%s_end", tag), run ? V_FETCH0 : 52'd0);
         in_fetch0 = run;
      end
   endtask

   task automatic pulse_clr(input string tag);
      run = 1'b0;
      clr = 1'b0;
      #2;
      check({tag, "_clr"}, 52'd0);
      @(negedge clk);
      clr = 1'b1;
      in_fetch0 = 1'b0;
      @(posedge clk); #1;
      check({tag, "_idle"}, 52'd0);
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] v;
      int          drop;

      clr = 1'b0; run = 1'b0; ir = 32'd0;
      #12;
      check("reset_outputs", 52'd0);
      check_state("reset_state", 4'd0);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk); #1;
      check("idle_no_run", 52'd0);

      // ADD r5 = r2 + r4, then run dropped
      exec("add", {5'h03, 4'd5, 4'd2, 4'd4, 15'd0}, 6);
      @(posedge clk); #1;
      check("add_stays_idle", 52'd0);
      // MUL rb=3 rc=1, run kept high so the next fetch follows directly
      exec("mul", {5'h0F, 4'd7, 4'd3, 4'd1, 15'h1234}, -1);
      exec("div", {5'h10, 4'd0, 4'd0, 4'd0, 15'd0}, -1);
      exec("nop", {5'h1E, 27'h5A5A5A5}, -1);
      // run dropped during T4 of an ADD: T5 still completes
      exec("add_drop", {5'h03, 4'd9, 4'd15, 4'd15, 15'd0}, 5);
      @(posedge clk); #1;
      check("drop_no_fetch", 52'd0);

      // Asynchronous clear in the middle of FETCH1
      ir = {5'h03, 4'd1, 4'd2, 4'd3, 15'd0};
      run = 1'b1;
      @(posedge clk); #1;
      check("clr_fetch0", V_FETCH0);
      @(posedge clk); #1;
      check("clr_fetch1", B_READ | B_MDR_EN);
      clr = 1'b0;
      #1;
      check("clr_async_outputs", 52'd0);
      check_state("clr_async_state", 4'd0);
      @(posedge clk); #1;
      check("clr_held", 52'd0);
      clr = 1'b1;
      @(posedge clk); #1;
      check("clr_restart", V_FETCH0);
      in_fetch0 = 1'b1;
      exec("after_clr", {5'h0C, 4'd14, 4'd13, 4'd12, 15'd0}, -1);

      for (int k = 0; k < 25; k++) begin
         op = 5'($urandom_range(0, 30));
         if (TRAP && is_illegal_op(op)) op = 5'h1E;
         v = {op, 27'($urandom)};
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         exec($sformatf("rnd%0d_op%0h", k, op), v, drop);
      end

      exec("illegal15", {5'h15, 4'd3, 4'd3, 4'd3, 15'd0}, -1);
      pulse_clr("post_illegal");
      exec("halt", {5'h1F, 27'd0}, -1);
      pulse_clr("post_halt");
      exec("recover", {5'h01, 4'd2, 4'd2, 4'd2, 15'd0}, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
